// File: rtl/pio_pkg.sv
// Shared definitions for the PIO port arbiter: PIO register offsets and FSM state codes.
package pio_pkg;

  localparam logic [2:0] PIO_DATA = 3'd0;
  localparam logic [2:0] PIO_DIR  = 3'd1;
  localparam logic [2:0] PIO_EDGE = 3'd3;
  localparam logic [2:0] PIO_SET  = 3'd4;
  localparam logic [2:0] PIO_CLR  = 3'd5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RDWAIT = 2'd2;
  localparam state_t DONE   = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping at N-1.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int unsigned offs);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + (IDX_W+1)'(offs);
    if (sum >= (IDX_W+1)'(N)) begin
      sum = sum - (IDX_W+1)'(N);
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  // Scan candidates in rotation order and keep the first one requesting
  always_comb begin : p_pick
    logic [IDX_W-1:0] cand;
    logic             found;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] sel;
    found = 1'b0;
    gnt   = '0;
    sel   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = wrap_add(ptr_i, i);
      if (req_i[cand] && !found) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        sel       = cand;
      end else begin
        found = found;
      end
    end
    grant_o = gnt;
    idx_o   = sel;
    valid_o = found;
  end

endmodule

// File: rtl/pio_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM PIO slave among NUM_REQ requesters, one op per grant.
module pio_port_arbiter
  import pio_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         pio_address,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [DATA_W-1:0]         pio_writedata,
  input  logic [DATA_W-1:0]         pio_readdata
);

  localparam int                 IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 wr_q, wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 cs_q, cs_d;
  logic                 wn_q, wn_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   grant_s;
  logic [IDX_W-1:0]     grant_idx_s;
  logic                 grant_valid_s;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .idx_o   (grant_idx_s),
    .valid_o (grant_valid_s)
  );

  // Next-state and next-output logic; pio_* and ack are computed one cycle ahead so they leave flops
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    ack_d   = '0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          state_d = ACCESS;
          idx_d   = grant_idx_s;
          wr_d    = |(req_wr & grant_s);
          addr_d  = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[grant_idx_s*DATA_W +: DATA_W];
          cs_d    = 1'b1;
          wn_d    = ~(|(req_wr & grant_s));
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_d = DONE;
          ack_d   = ONE_HOT0 << idx_q;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        // Slave registers its read data, so it is valid here, one cycle after the address strobe
        state_d = DONE;
        rdata_d = pio_readdata;
        ack_d   = ONE_HOT0 << idx_q;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign ack            = ack_q;
  assign rsp_rdata      = rdata_q;
  assign busy           = busy_q;
  assign pio_address    = addr_q;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_writedata  = wdata_q;

endmodule
